// File: rtl/instr_pkg.sv
// Shared instruction header: decoded/issued instruction records, integer
// writeback record and the helper that builds an issued instruction.
// Register index fields are REG_IDX_W wide, so NUM_REGS must not exceed 32.
package instr_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned PC_W      = 32;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] idx;
  } reg_operand_t;

  typedef struct packed {
    reg_operand_t rs1;
    reg_operand_t rs2;
    reg_operand_t rd;
  } decode_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] cause;
  } except_t;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    decode_t         decode;
    except_t         except;
  } decoded_instr_t;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    decode_t         decode;
    except_t         except;
  } issued_instr_t;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] idx;
  } int_arch_reg_wb_t;

  function automatic issued_instr_t compose_issued_instr(
    input logic [PC_W-1:0] pc,
    input decode_t         decode,
    input except_t         except,
    input logic            valid
  );
    issued_instr_t r;
    r.valid  = valid;
    r.pc     = pc;
    r.decode = decode;
    r.except = except;
    return r;
  endfunction

endpackage

// File: rtl/sched_pkg.sv
// Scoreboard package: default sizing and the writeback hit counter.
// wb_hit_count takes a fixed-size port vector (SCHED_MAX_WB_PORTS); callers
// pad unused entries with valid = 0, so NUM_WB_PORTS may not exceed it.
package sched_pkg;
  import instr_pkg::*;

  localparam int unsigned SCHED_NUM_REGS     = 32;
  localparam int unsigned SCHED_NUM_WB_PORTS = 2;
  localparam int unsigned SCHED_CNT_W        = 2;
  localparam int unsigned SCHED_MAX_WB_PORTS = 8;

  // Number of writeback ports releasing register idx this cycle.
  function automatic int unsigned wb_hit_count(
    input logic [REG_IDX_W-1:0]                     idx,
    input int_arch_reg_wb_t [SCHED_MAX_WB_PORTS-1:0] wb
  );
    int unsigned n;
    n = 0;
    for (int unsigned p = 0; p < SCHED_MAX_WB_PORTS; p++) begin
      if (wb[p].valid && wb[p].idx == idx) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/sched_scoreboard_if.sv
// Issue-stage bundle between ID, the scoreboard and RF/writeback.
//   master : pipeline side (drives flush, stall, instr, writebacks)
//   slave  : scoreboard side (drives o_stall, o_instr, o_idle)
interface sched_scoreboard_if #(
  parameter int unsigned NUM_WB_PORTS = sched_pkg::SCHED_NUM_WB_PORTS
);
  import instr_pkg::*;

  logic                                i_flush;
  logic                                i_stall;
  decoded_instr_t                      i_instr;
  int_arch_reg_wb_t [NUM_WB_PORTS-1:0] i_int_reg_wb;
  logic                                o_stall;
  issued_instr_t                       o_instr;
  logic                                o_idle;

  modport master (
    output i_flush, i_stall, i_instr, i_int_reg_wb,
    input  o_stall, o_instr, o_idle
  );

  modport slave (
    input  i_flush, i_stall, i_instr, i_int_reg_wb,
    output o_stall, o_instr, o_idle
  );

endinterface

// File: rtl/sched_pend_cnt.sv
// Pending-write counter for one architectural register.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (pipeline flush), wins over inc/dec
//   inc      : one write to this register issued this cycle
//   dec      : number of writebacks releasing this register this cycle
//   cnt      : current pending count
module sched_pend_cnt #(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned DEC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec,
  output logic [CNT_W-1:0] cnt
);

  int unsigned      sum;
  logic             underflow;
  logic [CNT_W-1:0] cnt_next;

  // Issue only increments when the count has headroom or a release lands in
  // the same cycle, so sum - dec always fits back into CNT_W bits.
  always_comb begin
    sum       = 32'(cnt) + 32'(inc);
    underflow = sum < 32'(dec);
    cnt_next  = underflow ? '0 : CNT_W'(sum - 32'(dec));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else          cnt <= cnt_next;
  end

  // More releases than pending writes means a writeback nobody issued.
  assert property (@(posedge clk) disable iff (rst) clr || !underflow)
    else $error("sched_pend_cnt: writeback release underflow");

endmodule

// File: rtl/sched_scoreboard.sv
// In-order issue stage between ID and RF with per-register saturating
// pending-write counters (WAW allowed, multi-port writeback release).
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_log_fd     : log enable/descriptor, 0 disables issue logging
//   bus          : sched_scoreboard_if.slave (flush, stall, instr, writebacks
//                  in; stall to ID, registered issued instr, idle out)
// Configuration macro SCHED_WB_BYPASS_EN: when defined, same-cycle writeback
// releases count towards operand/destination readiness; when undefined,
// readiness uses the registered counters only (one extra wakeup cycle).
module sched_scoreboard
  import instr_pkg::*;
  import sched_pkg::*;
#(
  parameter int unsigned NUM_REGS     = SCHED_NUM_REGS,
  parameter int unsigned NUM_WB_PORTS = SCHED_NUM_WB_PORTS,
  parameter int unsigned CNT_W        = SCHED_CNT_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_log_fd,
  sched_scoreboard_if.slave bus
);

  localparam int unsigned      IDX_W   = $clog2(NUM_REGS);
  localparam int unsigned      DEC_W   = $clog2(NUM_WB_PORTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [DEC_W-1:0] dec [NUM_REGS];
  logic             inc [NUM_REGS];
  logic [NUM_REGS-1:0] pend;

  int_arch_reg_wb_t [SCHED_MAX_WB_PORTS-1:0] wb_pad;

  logic [IDX_W-1:0] rs1_idx, rs2_idx, rd_idx;
  logic             rs1_byp, rs2_byp, rd_byp;
  logic             rs1_ready, rs2_ready, rd_ready, can_issue;
  issued_instr_t    instr_q;

  always_comb begin
    wb_pad = '0;
    for (int unsigned p = 0; p < NUM_WB_PORTS; p++) wb_pad[p] = bus.i_int_reg_wb[p];
  end

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      dec[r] = DEC_W'(wb_hit_count(REG_IDX_W'(r), wb_pad));
    end
  end

  always_comb begin
    rs1_idx = bus.i_instr.decode.rs1.idx[IDX_W-1:0];
    rs2_idx = bus.i_instr.decode.rs2.idx[IDX_W-1:0];
    rd_idx  = bus.i_instr.decode.rd.idx[IDX_W-1:0];
`ifdef SCHED_WB_BYPASS_EN
    // Every pending write to a source retires this cycle, or a release frees
    // a destination slot this cycle.
    rs1_byp = 32'(cnt[rs1_idx]) == 32'(dec[rs1_idx]);
    rs2_byp = 32'(cnt[rs2_idx]) == 32'(dec[rs2_idx]);
    rd_byp  = dec[rd_idx] != '0;
`else
    rs1_byp = 1'b0;
    rs2_byp = 1'b0;
    rd_byp  = 1'b0;
`endif
    rs1_ready = !bus.i_instr.decode.rs1.valid || rs1_idx == '0 ||
                cnt[rs1_idx] == '0 || rs1_byp;
    rs2_ready = !bus.i_instr.decode.rs2.valid || rs2_idx == '0 ||
                cnt[rs2_idx] == '0 || rs2_byp;
    rd_ready  = !bus.i_instr.decode.rd.valid || rd_idx == '0 ||
                cnt[rd_idx] != CNT_MAX || rd_byp;
    can_issue = !bus.i_stall && bus.i_instr.valid && rs1_ready && rs2_ready && rd_ready;
  end

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      inc[r] = can_issue && bus.i_instr.decode.rd.valid &&
               rd_idx == IDX_W'(r) && r != 0;
    end
  end

  // x0 is hardwired zero and never tracked.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    sched_pend_cnt #(
      .CNT_W(CNT_W),
      .DEC_W(DEC_W)
    ) u_cnt (
      .clk(i_clk),
      .rst(i_rst),
      .clr(bus.i_flush),
      .inc(inc[r]),
      .dec(dec[r]),
      .cnt(cnt[r])
    );
  end

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) pend[r] = cnt[r] != '0;
  end

  // A non-issuing cycle loads a bubble unless downstream holds the stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)               instr_q <= '0;
    else if (bus.i_flush)    instr_q <= '0;
    else if (!bus.i_stall)   instr_q <= compose_issued_instr(bus.i_instr.pc,
                                          bus.i_instr.decode, bus.i_instr.except, can_issue);
  end

  assign bus.o_instr = instr_q;
  assign bus.o_stall = bus.i_stall ||
                       (bus.i_instr.valid && !(rs1_ready && rs2_ready && rd_ready));
  assign bus.o_idle  = ~|pend;

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (!i_rst && i_log_fd != '0 && !bus.i_stall) begin
      $display("[IS ] valid=%0b pc=%08h issue=%0b rdy=%0b%0b%0b pend=%h",
               bus.i_instr.valid, bus.i_instr.pc, can_issue,
               rs1_ready, rs2_ready, rd_ready, pend);
    end
  end
`endif

endmodule
